// File: rtl/lut_digit_mac.sv
// Sequential signed multiplier: builds a table of 0..8 multiples of A, then
// shift-accumulates one signed radix-16 digit of B per accepted beat, LSD first.
//
// state  | meaning
// IDLE   | waiting for start; last product and err held
// BUILD  | filling lut[2..8] with one add per cycle
// ACCUM  | accepting digits, accumulating signed shifted multiples
// DONE   | product presented until the consumer accepts it
module lut_digit_mac #(
  parameter int WIDTH_A    = 8,
  parameter int NUM_DIGITS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [WIDTH_A-1:0]                   a_in,
  output logic                                 busy,
  input  logic                                 digit_valid,
  input  logic [3:0]                           digit_mag,
  input  logic                                 digit_sign,
  output logic                                 digit_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [WIDTH_A+4*NUM_DIGITS-1:0] product,
  output logic                                 err
);

  localparam int LW = WIDTH_A + 4;
  localparam int PW = WIDTH_A + 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUILD = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic signed [WIDTH_A-1:0] a_q, a_d;
  logic signed [LW-1:0]     lut_q [0:8];
  logic signed [LW-1:0]     lut_d [0:8];
  logic [3:0]               k_q, k_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic signed [PW-1:0]     acc_q, acc_d;
  logic signed [PW-1:0]     product_q, product_d;
  logic                     err_q, err_d;

  logic                     mag_ok;
  logic signed [LW-1:0]     term;
  logic signed [PW-1:0]     acc_sum;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    lut_d     = lut_q;
    k_d       = k_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    product_d = product_q;
    err_d     = err_q;

    // Illegal magnitudes contribute nothing; negating zero keeps it zero.
    mag_ok = (digit_mag <= 4'd8);
    term   = '0;
    if (mag_ok) term = lut_q[digit_mag];
    if (digit_sign) term = -term;
    acc_sum = acc_q + (PW'(term) << {idx_q, 2'b00});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = signed'(a_in);
          lut_d    = '{default: '0};
          lut_d[1] = LW'(signed'(a_in));
          k_d      = 4'd2;
          idx_d    = '0;
          acc_d    = '0;
          err_d    = 1'b0;
          state_d  = S_BUILD;
        end
      end
      S_BUILD: begin
        lut_d[k_q] = lut_q[k_q - 4'd1] + LW'(a_q);
        if (k_q == 4'd8) state_d = S_ACCUM;
        else             k_d     = k_q + 4'd1;
      end
      S_ACCUM: begin
        if (digit_valid) begin
          acc_d = acc_sum;
          if (!mag_ok) err_d = 1'b1;
          if (idx_q == IW'(NUM_DIGITS - 1)) begin
            product_d = acc_sum;
            state_d   = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      lut_q     <= '{default: '0};
      k_q       <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      lut_q     <= lut_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      err_q     <= err_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign digit_ready = (state_q == S_ACCUM);
  assign out_valid   = (state_q == S_DONE);
  assign product     = product_q;
  assign err         = err_q;

endmodule
